// File: rtl/risc4bit_pkg.sv
// Shared definitions for the 4-bit RISC instruction-memory path: default widths,
// fetch FSM state encoding and derived memory depth.
`default_nettype none

package risc4bit_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;
  localparam int MEM_DEPTH  = 2 ** DEF_ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } fetch_state_e;

endpackage : risc4bit_pkg

`default_nettype wire

// File: rtl/imem_fetch_responder_if.sv
// Fetch and program-load bus between the CPU/boot side (master) and the
// instruction-memory responder (slave).
`default_nettype none

interface imem_fetch_responder_if #(
  parameter int ADDR_W = risc4bit_pkg::DEF_ADDR_W,
  parameter int DATA_W = risc4bit_pkg::DEF_DATA_W
);

  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ready;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_data;
  logic              load_start;
  logic              load_en;
  logic [DATA_W-1:0] load_data;
  logic              load_done;

  modport master (
    output fetch_req,
    output fetch_addr,
    input  fetch_ready,
    input  fetch_valid,
    input  fetch_data,
    output load_start,
    output load_en,
    output load_data,
    input  load_done
  );

  modport slave (
    input  fetch_req,
    input  fetch_addr,
    output fetch_ready,
    output fetch_valid,
    output fetch_data,
    input  load_start,
    input  load_en,
    input  load_data,
    output load_done
  );

endinterface : imem_fetch_responder_if

`default_nettype wire

// File: rtl/imem_array.sv
// Program store: one write port, one read port that captures a word into a
// register when enabled; asynchronous active-low reset clears every word.
`default_nettype none

module imem_array #(
  parameter int ADDR_W = risc4bit_pkg::DEF_ADDR_W,
  parameter int DATA_W = risc4bit_pkg::DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Read samples pre-write contents when both ports hit the same word on one edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      if (we_i) begin
        mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
        rdata_q <= mem_q[raddr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule : imem_array

`default_nettype wire

// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder: accepts CPU fetches, answers after WAIT_CYCLES
// wait states, and owns the sequential program-load pointer.
`default_nettype none

module imem_fetch_responder
  import risc4bit_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  imem_fetch_responder_if.slave bus_if
);

  localparam int                CNT_W     = 4;
  localparam bit                ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [CNT_W-1:0]  CNT_INIT  = ZERO_WAIT ? '0 : 4'(WAIT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  fetch_state_e      state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              valid_q;

  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] ptr_d;
  logic              load_done_q;
  logic              load_done_d;

  logic              ready;
  logic              accept;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              we;

  // Loading owns the cycle in IDLE, so a fetch waits until the load port is quiet.
  always_comb begin
    ready   = rst && (state_q == IDLE) && !bus_if.load_en && !bus_if.load_start;
    accept  = ready && bus_if.fetch_req;
    rd_en   = ((state_q == WAIT) && (cnt_q == '0)) || (accept && ZERO_WAIT);
    rd_addr = (state_q == IDLE) ? bus_if.fetch_addr : addr_q;
    we      = bus_if.load_en && !bus_if.load_start;
  end

  always_comb begin
    ptr_d       = ptr_q;
    load_done_d = 1'b0;
    if (bus_if.load_start) begin
      ptr_d = '0;
    end else if (bus_if.load_en) begin
      ptr_d       = ptr_q + 1'b1;
      load_done_d = (ptr_q == LAST_ADDR);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            addr_q <= bus_if.fetch_addr;
            if (ZERO_WAIT) begin
              state_q <= RESP;
              valid_q <= 1'b1;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q <= RESP;
            valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q       <= '0;
      load_done_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      load_done_q <= load_done_d;
    end
  end

  imem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_imem_array (
    .clk     (clk),
    .rst     (rst),
    .we_i    (we),
    .waddr_i (ptr_q),
    .wdata_i (bus_if.load_data),
    .re_i    (rd_en),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  assign bus_if.fetch_ready = ready;
  assign bus_if.fetch_valid = valid_q;
  assign bus_if.fetch_data  = rd_data;
  assign bus_if.load_done   = load_done_q;

endmodule : imem_fetch_responder

`default_nettype wire

// File: tb/tb_imem_fetch_responder.sv
// Directed bench for imem_fetch_responder: three builds (1, 0 and 3 wait states)
// driven one at a time through a shared stimulus mux.
`default_nettype none

module tb_imem_fetch_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic [3:0] addr;
  logic       lstart;
  logic       len;
  logic [7:0] ldata;
  int         sel;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imem_fetch_responder_if #(.ADDR_W(4), .DATA_W(8)) ifa ();
  imem_fetch_responder_if #(.ADDR_W(4), .DATA_W(8)) ifb ();
  imem_fetch_responder_if #(.ADDR_W(4), .DATA_W(8)) ifc ();

  assign ifa.fetch_req  = (sel == 0) && req;
  assign ifa.fetch_addr = addr;
  assign ifa.load_start = (sel == 0) && lstart;
  assign ifa.load_en    = (sel == 0) && len;
  assign ifa.load_data  = ldata;
  assign ifb.fetch_req  = (sel == 1) && req;
  assign ifb.fetch_addr = addr;
  assign ifb.load_start = (sel == 1) && lstart;
  assign ifb.load_en    = (sel == 1) && len;
  assign ifb.load_data  = ldata;
  assign ifc.fetch_req  = (sel == 2) && req;
  assign ifc.fetch_addr = addr;
  assign ifc.load_start = (sel == 2) && lstart;
  assign ifc.load_en    = (sel == 2) && len;
  assign ifc.load_data  = ldata;

  imem_fetch_responder #(.ADDR_W(4), .DATA_W(8), .WAIT_CYCLES(1)) dut_a (
    .clk (clk), .rst (rst), .bus_if (ifa.slave));
  imem_fetch_responder #(.ADDR_W(4), .DATA_W(8), .WAIT_CYCLES(0)) dut_b (
    .clk (clk), .rst (rst), .bus_if (ifb.slave));
  imem_fetch_responder #(.ADDR_W(4), .DATA_W(8), .WAIT_CYCLES(3)) dut_c (
    .clk (clk), .rst (rst), .bus_if (ifc.slave));

  logic       o_ready;
  logic       o_valid;
  logic       o_done;
  logic [7:0] o_data;

  always_comb begin
    o_ready = ifa.fetch_ready;
    o_valid = ifa.fetch_valid;
    o_done  = ifa.load_done;
    o_data  = ifa.fetch_data;
    if (sel == 1) begin
      o_ready = ifb.fetch_ready;
      o_valid = ifb.fetch_valid;
      o_done  = ifb.load_done;
      o_data  = ifb.fetch_data;
    end else if (sel == 2) begin
      o_ready = ifc.fetch_ready;
      o_valid = ifc.fetch_valid;
      o_done  = ifc.load_done;
      o_data  = ifc.fetch_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one fetch; optionally pulse load_en so its write lands on tick number wr_at
  // (tick 1 is the accept edge). Checks ready, latency, data, and the post-pulse hold.
  task automatic do_fetch(input string tag, input logic [3:0] a, input logic [7:0] exp,
                          input int lat, input int wr_at, input logic [7:0] wd);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    req  = 1'b1;
    addr = a;
    #1;
    chk({tag, "_ready"}, 32'(o_ready), 32'd1);
    while (n < 12 && !got) begin
      len   = (n + 1 == wr_at);
      ldata = wd;
      tick();
      n++;
      if (n == 1) req = 1'b0;
      len = 1'b0;
      if (o_valid) got = 1'b1;
    end
    chk({tag, "_latency"}, 32'(n), 32'(lat));
    chk({tag, "_data"}, 32'(o_data), 32'(exp));
    tick();
    chk({tag, "_valid_drop"}, 32'(o_valid), 32'd0);
    chk({tag, "_data_hold"}, 32'(o_data), 32'(exp));
  endtask

  task automatic load_program(input string tag, input logic [7:0] base);
    lstart = 1'b1;
    tick();
    lstart = 1'b0;
    for (int i = 0; i < 16; i++) begin
      len   = 1'b1;
      ldata = base + 8'(i);
      tick();
      chk($sformatf("%s_done_%0d", tag, i), 32'(o_done), (i == 15) ? 32'd1 : 32'd0);
    end
    len = 1'b0;
    tick();
    chk({tag, "_done_clear"}, 32'(o_done), 32'd0);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; addr = '0; lstart = 1'b0; len = 1'b0; ldata = '0; sel = 0;
    #2 rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();

    // 1: reset mid-fetch and mid-load drops everything and clears the store.
    lstart = 1'b1; tick(); lstart = 1'b0;
    len = 1'b1; ldata = 8'hAA; tick(); tick();
    len = 1'b0; req = 1'b1; addr = 4'd5; tick();
    req = 1'b0; len = 1'b1; ldata = 8'hBB; rst = 1'b0;
    #1;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_ready_loading", 32'(o_ready), 32'd0);
    len = 1'b0; req = 1'b1;
    tick();
    chk("rst_ready_req", 32'(o_ready), 32'd0);
    chk("rst_no_resp", 32'(o_valid), 32'd0);
    tick();
    rst = 1'b1; req = 1'b0;
    tick();
    chk("rel_no_resp", 32'(o_valid), 32'd0);
    len = 1'b1; ldata = 8'h55; tick(); len = 1'b0;
    do_fetch("t1_ptr0", 4'd0, 8'h55, 2, 0, 8'h00);
    do_fetch("t1_cleared", 4'd1, 8'h00, 2, 0, 8'h00);
    do_fetch("t1_addr5", 4'd5, 8'h00, 2, 0, 8'h00);

    // 2: full program load and single fetch.
    load_program("t2", 8'h10);
    do_fetch("t2_addr3", 4'd3, 8'h13, 2, 0, 8'h00);

    // 3: back-to-back requests, one response per three cycles.
    req = 1'b1; addr = 4'd0;
    for (int c = 0; c < 9; c++) begin
      #1;
      chk($sformatf("t3_ready_c%0d", c), 32'(o_ready), (c % 3 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("t3_valid_c%0d", c), 32'(o_valid), (c % 3 == 2) ? 32'd1 : 32'd0);
      if (c % 3 == 2) chk($sformatf("t3_data_c%0d", c), 32'(o_data), 32'(8'h10 + 8'(c / 3)));
      tick();
      if (c == 6) req = 1'b0;
      else if (c % 3 == 0) addr = 4'(c / 3 + 1);
    end

    // 4: load_en blocks a same-cycle request; request then sees the new word.
    req = 1'b1; addr = 4'd0; len = 1'b1; ldata = 8'hA0;
    #1;
    chk("t4_blocked", 32'(o_ready), 32'd0);
    tick();
    len = 1'b0;
    #1;
    chk("t4_still_idle", 32'(o_ready), 32'd1);
    do_fetch("t4_new_word", 4'd0, 8'hA0, 2, 0, 8'h00);

    // 6a: write lands on the RESP-entry edge -> old word returned.
    do_fetch("t6_resp_edge", 4'd1, 8'h11, 2, 2, 8'hB1);
    do_fetch("t6_after", 4'd1, 8'hB1, 2, 0, 8'h00);

    // 5: zero-wait build, pointer wrap.
    sel = 1;
    tick();
    load_program("t5", 8'h10);
    do_fetch("t5_addr15", 4'd15, 8'h1F, 1, 0, 8'h00);
    len = 1'b1; ldata = 8'hE0; tick(); len = 1'b0;
    chk("t5_wrap_no_done", 32'(o_done), 32'd0);
    do_fetch("t5_wrap", 4'd0, 8'hE0, 1, 0, 8'h00);

    // 6b: three-wait build, write during WAIT is seen; write on RESP edge is not.
    sel = 2;
    tick();
    do_fetch("t6_in_wait", 4'd0, 8'hC6, 4, 2, 8'hC6);
    do_fetch("t6_resp_edge3", 4'd1, 8'h00, 4, 4, 8'hD7);
    do_fetch("t6_after3", 4'd1, 8'hD7, 4, 0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_imem_fetch_responder

`default_nettype wire
